// File: rtl/switch_press_conditioner.sv
// Push-button conditioner for the display counter stage.
// This block synchronises the raw button, then debounces it. It produces
// one-cycle press and release pulses and an auto-repeat pulse train while the
// button stays held. o_Step merges press and repeat so the counter can use it
// directly as an increment enable.
module switch_press_conditioner #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int HOLD_LIMIT     = 12500000,
    parameter int REPEAT_LIMIT   = 5000000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release,
    output logic o_Repeat,
    output logic o_Step
);

    localparam int DEB_W    = $clog2(DEBOUNCE_LIMIT);
    localparam int HOLD_MAX = (HOLD_LIMIT > REPEAT_LIMIT) ? HOLD_LIMIT : REPEAT_LIMIT;
    localparam int HOLD_W   = $clog2(HOLD_MAX);

    localparam logic [DEB_W-1:0]  DEB_LAST    = DEB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_LIMIT - 1);
    localparam logic [HOLD_W-1:0] REPEAT_LAST = HOLD_W'(REPEAT_LIMIT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HOLD   = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic              r_Sync_Meta;
    logic              r_Sync;
    logic [DEB_W-1:0]  r_Deb_Cnt;
    state_t            r_State;
    state_t            w_Next_State;
    logic [HOLD_W-1:0] r_Hold_Cnt;
    logic [HOLD_W-1:0] w_Next_Hold_Cnt;
    logic              w_Accept;
    logic              w_Rise;
    logic              w_Fall;
    logic              w_Repeat_Due;

    // The debounced level flips on the last cycle of a long enough disagreement.
    assign w_Accept = (r_Sync != o_Switch) && (r_Deb_Cnt == DEB_LAST);
    assign w_Rise   = w_Accept & r_Sync;
    assign w_Fall   = w_Accept & ~r_Sync;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Sync_Meta <= 1'b0;
            r_Sync      <= 1'b0;
        end else begin
            r_Sync_Meta <= i_Switch;
            r_Sync      <= r_Sync_Meta;
        end
    end

    // Debounce: accept the synced level only after it has disagreed long enough
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_Deb_Cnt <= '0;
            o_Switch  <= 1'b0;
        end else if (r_Sync != o_Switch) begin
            if (r_Deb_Cnt == DEB_LAST) begin
                o_Switch  <= r_Sync;
                r_Deb_Cnt <= '0;
            end else begin
                r_Deb_Cnt <= r_Deb_Cnt + DEB_W'(1);
            end
        end else begin
            r_Deb_Cnt <= '0;
        end
    end

    // Registered event pulses, aligned with the first cycle of the new level
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Press   <= 1'b0;
            o_Release <= 1'b0;
            o_Repeat  <= 1'b0;
            o_Step    <= 1'b0;
        end else begin
            o_Press   <= w_Rise;
            o_Release <= w_Fall;
            o_Repeat  <= w_Repeat_Due;
            o_Step    <= w_Rise | w_Repeat_Due;
        end
    end

    // Hold/repeat FSM state and hold counter registers
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_State    <= S_IDLE;
            r_Hold_Cnt <= '0;
        end else begin
            r_State    <= w_Next_State;
            r_Hold_Cnt <= w_Next_Hold_Cnt;
        end
    end

    // Next-state logic: a release always wins over a repeat due in that cycle
    always_comb begin
        w_Next_State    = r_State;
        w_Next_Hold_Cnt = r_Hold_Cnt;
        w_Repeat_Due    = 1'b0;
        case (r_State)
            S_IDLE: begin
                w_Next_Hold_Cnt = '0;
                if (w_Rise) begin
                    w_Next_State = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_Fall) begin
                    w_Next_State    = S_IDLE;
                    w_Next_Hold_Cnt = '0;
                end else if (r_Hold_Cnt == HOLD_LAST) begin
                    w_Repeat_Due    = 1'b1;
                    w_Next_Hold_Cnt = '0;
                    w_Next_State    = S_REPEAT;
                end else begin
                    w_Next_Hold_Cnt = r_Hold_Cnt + HOLD_W'(1);
                end
            end
            S_REPEAT: begin
                if (w_Fall) begin
                    w_Next_State    = S_IDLE;
                    w_Next_Hold_Cnt = '0;
                end else if (r_Hold_Cnt == REPEAT_LAST) begin
                    w_Repeat_Due    = 1'b1;
                    w_Next_Hold_Cnt = '0;
                end else begin
                    w_Next_Hold_Cnt = r_Hold_Cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_Next_State    = S_IDLE;
                w_Next_Hold_Cnt = '0;
            end
        endcase
    end

endmodule
